// File: rtl/param_matrix_multiplier.sv
// Sequential N x N matrix multiplier: reads A and B one element per cycle through address ports,
// accumulates N products per result element and hands results out row-major over a strobe/ack handshake.
module param_matrix_multiplier #(
  parameter int N        = 4,
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 32,
  parameter int ACC_W    = 2 * DATA_W + $clog2(N),
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  localparam int IDX_W   = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  a_i,
  output logic [IDX_W-1:0]  a_j,
  input  logic [DATA_W-1:0] a_in,
  output logic [IDX_W-1:0]  b_i,
  output logic [IDX_W-1:0]  b_j,
  input  logic [DATA_W-1:0] b_in,
  output logic [OUT_W-1:0]  z_out,
  output logic [IDX_W-1:0]  z_i,
  output logic [IDX_W-1:0]  z_j,
  output logic              z_stb,
  input  logic              z_ack,
  output logic              busy,
  output logic              done
);

  localparam int EXT_W = ACC_W - 2 * DATA_W;
  localparam int HI_W  = ACC_W - OUT_W;
  localparam logic SGN = (SIGNED != 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [ACC_W-1:0] S_MAX = {{(HI_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {{(HI_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = {{HI_W{1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx;
  logic [IDX_W-1:0]     i_r;
  logic [IDX_W-1:0]     j_r;
  logic [IDX_W-1:0]     k_r;
  logic [ACC_W-1:0]     acc_r;
  logic [2*DATA_W-1:0]  a_ext_s;
  logic [2*DATA_W-1:0]  b_ext_s;
  logic [2*DATA_W-1:0]  prod_full_s;
  logic [ACC_W-1:0]     prod_s;
  logic [ACC_W-1:0]     sum_s;
  logic                 last_elem_s;

  // Clamp or truncate the wide accumulator into the result width.
  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] v);
    logic [OUT_W-1:0] r;
    if (SATURATE == 0) begin
      r = v[OUT_W-1:0];
    end else if (SGN) begin
      if ($signed(v) > $signed(S_MAX)) begin
        r = S_MAX[OUT_W-1:0];
      end else if ($signed(v) < $signed(S_MIN)) begin
        r = S_MIN[OUT_W-1:0];
      end else begin
        r = v[OUT_W-1:0];
      end
    end else if (v > U_MAX) begin
      r = {OUT_W{1'b1}};
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

  assign a_i = i_r;
  assign a_j = k_r;
  assign b_i = k_r;
  assign b_j = j_r;

  // Operands widened to 2*DATA_W so one multiplier serves both signed and unsigned modes.
  always_comb begin
    a_ext_s     = {{DATA_W{a_in[DATA_W-1] & SGN}}, a_in};
    b_ext_s     = {{DATA_W{b_in[DATA_W-1] & SGN}}, b_in};
    prod_full_s = a_ext_s * b_ext_s;
    prod_s      = {{EXT_W{prod_full_s[2*DATA_W-1] & SGN}}, prod_full_s};
    if (k_r == {IDX_W{1'b0}}) begin
      sum_s = prod_s;
    end else begin
      sum_s = acc_r + prod_s;
    end
    last_elem_s = (i_r == LAST) && (j_r == LAST);
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx = MAC;
        end else begin
          state_nx = state_r;
        end
      end
      MAC: begin
        if (k_r == LAST) begin
          state_nx = OUT;
        end else begin
          state_nx = MAC;
        end
      end
      OUT: begin
        if (!z_ack) begin
          state_nx = OUT;
        end else if (last_elem_s) begin
          state_nx = DONE;
        end else begin
          state_nx = MAC;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      z_stb   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx;
      z_stb   <= (state_nx == OUT);
      busy    <= (state_nx == MAC) || (state_nx == OUT);
      done    <= (state_nx == DONE);
    end
  end

  // Counters, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r   <= {IDX_W{1'b0}};
      j_r   <= {IDX_W{1'b0}};
      k_r   <= {IDX_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
      z_out <= {OUT_W{1'b0}};
      z_i   <= {IDX_W{1'b0}};
      z_j   <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            i_r <= {IDX_W{1'b0}};
            j_r <= {IDX_W{1'b0}};
            k_r <= {IDX_W{1'b0}};
          end
        end
        MAC: begin
          acc_r <= sum_s;
          if (k_r == LAST) begin
            z_out <= conv(sum_s);
            z_i   <= i_r;
            z_j   <= j_r;
            k_r   <= {IDX_W{1'b0}};
          end else begin
            k_r <= k_r + IDX_W'(1);
          end
        end
        OUT: begin
          if (z_ack) begin
            if (last_elem_s) begin
              i_r <= {IDX_W{1'b0}};
              j_r <= {IDX_W{1'b0}};
            end else if (j_r == LAST) begin
              j_r <= {IDX_W{1'b0}};
              i_r <= i_r + IDX_W'(1);
            end else begin
              j_r <= j_r + IDX_W'(1);
            end
          end
        end
        default: begin
          k_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Scoreboard bench: stimulus pushes hand-computed results, negedge monitors pop and compare
// whenever a DUT presents an accepted result.
module tb_param_matrix_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2, z_ack;
  logic [1:0]  a_i, a_j, b_i, b_j, z_i, z_j;
  logic [31:0] a_in, b_in, z_out;
  logic        z_stb, busy, done;
  logic [31:0] a_mem [4][4];
  logic [31:0] b_mem [4][4];

  assign a_in = a_mem[a_i][a_j];
  assign b_in = b_mem[b_i][b_j];

  param_matrix_multiplier #(.N(4), .DATA_W(32), .OUT_W(32), .SIGNED(1), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_i(a_i), .a_j(a_j), .a_in(a_in),
    .b_i(b_i), .b_j(b_j), .b_in(b_in),
    .z_out(z_out), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
    .busy(busy), .done(done)
  );

  // Two N=2 16-bit instances fed A=B=0x7FFF, one saturating and one truncating.
  logic [15:0] big = 16'h7FFF;
  logic        ack_hi = 1'b1;
  logic        sa_ai, sa_aj, sa_bi, sa_bj, sa_zi, sa_zj, sa_stb, sa_busy, sa_done;
  logic        tr_ai, tr_aj, tr_bi, tr_bj, tr_zi, tr_zj, tr_stb, tr_busy, tr_done;
  logic [15:0] sa_z, tr_z;

  param_matrix_multiplier #(.N(2), .DATA_W(16), .OUT_W(16), .SIGNED(1), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start2),
    .a_i(sa_ai), .a_j(sa_aj), .a_in(big),
    .b_i(sa_bi), .b_j(sa_bj), .b_in(big),
    .z_out(sa_z), .z_i(sa_zi), .z_j(sa_zj), .z_stb(sa_stb), .z_ack(ack_hi),
    .busy(sa_busy), .done(sa_done)
  );

  param_matrix_multiplier #(.N(2), .DATA_W(16), .OUT_W(16), .SIGNED(1), .SATURATE(0)) dut_trn (
    .clk(clk), .rst(rst), .start(start2),
    .a_i(tr_ai), .a_j(tr_aj), .a_in(big),
    .b_i(tr_bi), .b_j(tr_bj), .b_in(big),
    .z_out(tr_z), .z_i(tr_zi), .z_j(tr_zj), .z_stb(tr_stb), .z_ack(ack_hi),
    .busy(tr_busy), .done(tr_done)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [39:0] sb_q [$];
  logic [17:0] q_sat [$];
  logic [17:0] q_trn [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main monitor: one pop per accepted result.
  always @(negedge clk) begin : mon_main
    logic [39:0] e;
    if (!rst && z_stb && z_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {28'd0, z_i, z_j}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("z_i", 32'(z_i), 32'(e[39:36]));
        chk("z_j", 32'(z_j), 32'(e[35:32]));
        chk("z_out", z_out, e[31:0]);
      end
    end
  end

  // Monitors for the two N=2 instances (ack tied high).
  always @(negedge clk) begin : mon_small
    logic [17:0] e;
    if (!rst && sa_stb) begin
      if (q_sat.size() == 0) begin
        chk("sat_unexpected", 32'(sa_z), 32'hFFFF_FFFF);
      end else begin
        e = q_sat.pop_front();
        chk("sat_idx", {30'd0, sa_zi, sa_zj}, {30'd0, e[17:16]});
        chk("sat_z_out", 32'(sa_z), 32'(e[15:0]));
      end
    end
    if (!rst && tr_stb) begin
      if (q_trn.size() == 0) begin
        chk("trn_unexpected", 32'(tr_z), 32'hFFFF_FFFF);
      end else begin
        e = q_trn.pop_front();
        chk("trn_idx", {30'd0, tr_zi, tr_zj}, {30'd0, e[17:16]});
        chk("trn_z_out", 32'(tr_z), 32'(e[15:0]));
      end
    end
  end

  // mode 0: A=identity, B[r][c]=4r+c; mode 1: A=2, B=3; mode 2: A=-3, B=5
  task automatic set_mats(input int mode);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0: begin a_mem[r][c] = (r == c) ? 32'd1 : 32'd0; b_mem[r][c] = 32'(4 * r + c); end
          1: begin a_mem[r][c] = 32'd2; b_mem[r][c] = 32'd3; end
          default: begin a_mem[r][c] = 32'hFFFF_FFFD; b_mem[r][c] = 32'd5; end
        endcase
      end
    end
  endtask

  task automatic push_exp(input int mode);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0: v = 32'(4 * r + c);
          1: v = 32'd24;
          default: v = 32'hFFFF_FFC4;
        endcase
        sb_q.push_back({4'(r), 4'(c), v});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    int t;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; z_ack = 1'b1;
    set_mats(0);
    tick(); tick();
    chk("rst_z_stb", 32'(z_stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z_out", z_out, 32'd0);
    chk("rst_z_idx", {28'd0, z_i, z_j}, 32'd0);
    chk("rst_addr", {24'd0, a_i, a_j, b_i, b_j}, 32'd0);
    rst = 1'b0;

    // N=2 saturate / truncate instances
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        q_sat.push_back({1'(r), 1'(c), 16'h7FFF});
        q_trn.push_back({1'(r), 1'(c), 16'h0002});
      end
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;

    // identity x B, ack high, latency
    push_exp(0);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    wait_done(cnt);
    chk("latency_identity", 32'(cnt), 32'd80);
    chk("sb_empty_identity", 32'(sb_q.size()), 32'd0);
    repeat (5) tick();
    chk("done_held", 32'(done), 32'd1);
    chk("done_not_busy", 32'(busy), 32'd0);

    // all 2 x all 3 -> 24, started from DONE
    set_mats(1);
    push_exp(1);
    pulse_start();
    chk("restart_done_low", 32'(done), 32'd0);
    wait_done(cnt);
    chk("latency_const", 32'(cnt), 32'd80);

    // all -3 x all 5 -> -60
    set_mats(2);
    push_exp(2);
    pulse_start();
    wait_done(cnt);
    chk("sb_empty_signed", 32'(sb_q.size()), 32'd0);

    // back-pressure on (0,1)
    set_mats(0);
    push_exp(0);
    pulse_start();
    for (t = 0; t < 20 && !z_stb; t++) tick();
    chk("first_out_idx", {28'd0, z_i, z_j}, 32'd0);
    tick();
    z_ack = 1'b0;
    for (t = 0; t < 20 && !z_stb; t++) tick();
    for (int h = 0; h < 10; h++) begin
      chk("hold_z_stb", 32'(z_stb), 32'd1);
      chk("hold_z_out", z_out, 32'd1);
      chk("hold_z_idx", {28'd0, z_i, z_j}, 32'd1);
      chk("hold_addr", {24'd0, a_i, a_j, b_i, b_j}, 32'd1);
      tick();
    end
    z_ack = 1'b1;
    wait_done(cnt);
    chk("sb_empty_hold", 32'(sb_q.size()), 32'd0);

    // reset while in MAC at (1,2), then a full rerun
    push_exp(0);
    pulse_start();
    for (t = 0; t < 200 && !(busy && !z_stb && a_i == 2'd1 && b_j == 2'd2); t++) tick();
    chk("reached_mac_1_2", 32'(busy && !z_stb && a_i == 2'd1 && b_j == 2'd2), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("midrst_z_stb", 32'(z_stb), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_z_out", z_out, 32'd0);
    push_exp(0);
    pulse_start();
    wait_done(cnt);
    chk("latency_after_rst", 32'(cnt), 32'd80);
    chk("sb_empty_final", 32'(sb_q.size()), 32'd0);
    chk("sat_q_empty", 32'(q_sat.size()), 32'd0);
    chk("trn_q_empty", 32'(q_trn.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_matrix_multiplier.md
PARAM_MATRIX_MULTIPLIER -- requirements
Module: param_matrix_multiplier

Interface
REQ-001 Parameter N, default 4, matrix dimension (N >= 2); IDX_W = max(1, clog2(N)).
REQ-002 Parameter DATA_W, default 32, width of each A/B element.
REQ-003 Parameter OUT_W, default 32, width of each result element.
REQ-004 Parameter ACC_W, default 2*DATA_W+clog2(N), internal accumulator width.
REQ-005 Parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-006 Parameter SATURATE, default 1; 1 = clamp accumulator to OUT_W range, 0 = keep low OUT_W bits.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  request a new multiplication; sampled in IDLE or DONE.
REQ-010 a_i, a_j  out  IDX_W each  row/column address of the A element being read.
REQ-011 a_in  in  DATA_W  A[a_i][a_j], combinationally valid in the same cycle as the address.
REQ-012 b_i, b_j  out  IDX_W each  row/column address of the B element being read.
REQ-013 b_in  in  DATA_W  B[b_i][b_j], combinationally valid in the same cycle as the address.
REQ-014 z_out  out  OUT_W  result element value.
REQ-015 z_i, z_j  out  IDX_W each  result element row/column.
REQ-016 z_stb  out  1  z_out/z_i/z_j valid.
REQ-017 z_ack  in  1  consumer accepts the current result.
REQ-018 busy  out  1  high in MAC and OUT states.
REQ-019 done  out  1  high while in DONE state.

Function
REQ-020 FSM states: IDLE, MAC, OUT, DONE; counters i, j, k (IDX_W each); accumulator acc (ACC_W).
REQ-021 IDLE or DONE with start=1 at a rising edge -> MAC with i=j=k=0 on the next cycle; done falls in that cycle.
REQ-022 In MAC: a_i=i, a_j=k, b_i=k, b_j=j; product = a_in*b_in, sign- or zero-extended to ACC_W per SIGNED.
REQ-023 In MAC: if k==0, acc <= product; else acc <= acc + product; k increments each cycle.
REQ-024 In MAC with k==N-1: z_out <= conv(acc+product), z_i <= i, z_j <= j, k <= 0, state -> OUT.
REQ-025 conv: SATURATE=1 clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (SIGNED=1) or [0, 2^OUT_W-1] (SIGNED=0); SATURATE=0 truncates to the low OUT_W bits.
REQ-026 In OUT: z_stb=1; z_out, z_i, z_j and all addresses held stable until z_ack=1 is sampled.
REQ-027 OUT with z_ack=1 -> z_stb=0 next cycle; if (i,j)==(N-1,N-1) go to DONE; else advance j, wrapping to 0 with i+1, and return to MAC.
REQ-028 Results are produced in row-major order; each element takes N MAC cycles plus at least 1 OUT cycle.
REQ-029 Total latency with z_ack tied high: N*N*(N+1) cycles from the first MAC cycle to DONE entry.
REQ-030 start in MAC or OUT is ignored; z_ack outside OUT is ignored.
REQ-031 Continuously high z_ack consumes exactly one result per OUT visit.
REQ-032 DONE holds done=1 until start is sampled or rst is asserted.

Reset
REQ-033 rst=1 at a rising edge -> IDLE; i=j=k=0; acc=0; z_out=0; z_i=z_j=0; z_stb=0; busy=0; done=0; all addresses 0.
REQ-034 rst overrides start and z_ack in the same cycle, discards any partial result, and is honoured from any state, including mid-operation.

Verification
REQ-035 N=4, A=identity, B[r][c]=4r+c, z_ack tied high -> 16 results in row-major order equal to B; done asserted N*N*(N+1) cycles after the first MAC cycle.
REQ-036 N=4, A all 2, B all 3 -> every z_out=24; done stays high until the next start.
REQ-037 Hold z_ack low for 10 cycles while (0,1) is presented -> z_stb, z_out, z_i=0, z_j=1 and all addresses stay stable; the sequence resumes on ack.
REQ-038 N=2, DATA_W=OUT_W=16, SIGNED=1, A=B all 0x7FFF: SATURATE=1 -> z_out=0x7FFF; SATURATE=0 -> z_out=0x0002 (low 16 bits of 2*0x3FFF0001).
REQ-039 N=4, SIGNED=1, A all -3, B all 5 -> every z_out=-60 (0xFFFFFFC4, OUT_W=32).
REQ-040 Assert rst for 1 cycle while in MAC at (1,2) -> z_stb=busy=done=0 on the next cycle; a new start yields the full result sequence from (0,0).
